// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, error/BREAK detection and a
// show-ahead result FIFO drained by a valid/ready handshake.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rxd,
  input  logic                          uart_rx_en,
  input  logic [DIV_W-1:0]              cfg_div,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_break,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_BITS + 3;
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, line_q, line_d;
  logic [DIV_W-1:0]     div_q, div_d, cnt_q, cnt_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d, pbit_q, pbit_d, ferr_q, ferr_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;

  logic [DIV_W-1:0]     div_in, mid;
  logic                 last, samp, vote, perr, fe_now, brk_now;
  logic                 push, pop, full, do_push;
  logic [EW-1:0]        entry;

  always_comb begin
    state_d = state_q;  sync1_d = sync1_q; sync2_d = sync2_q; line_d = line_q;
    div_d   = div_q;    cnt_d   = cnt_q;   s0_d    = s0_q;    s1_d   = s1_q;
    bit_d   = bit_q;    stop_d  = stop_q;  pbit_d  = pbit_q;  ferr_d = ferr_q;
    shift_d = shift_q;  push    = 1'b0;    entry   = '0;

    if (uart_rx_en) begin
      sync1_d = uart_rxd;
      sync2_d = sync1_q;
      line_d  = sync2_q;
    end

    div_in  = (cfg_div < DIV_W'(4)) ? DIV_W'(4) : cfg_div;
    mid     = div_q >> 1;
    last    = (cnt_q == div_q - 1'b1);
    samp    = (cnt_q == mid + 1'b1);
    vote    = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
    perr    = (PARITY != 0) ? ((^shift_q ^ pbit_q) != (PARITY == 1)) : 1'b0;
    fe_now  = ferr_q | ~vote;
    brk_now = (shift_q == '0) && (PARITY == 0 || !pbit_q) && !vote && !stop_q;

    if (cnt_q == mid - 1'b1) s0_d = sync2_q;
    if (cnt_q == mid)        s1_d = sync2_q;
    if (state_q != S_IDLE)   cnt_d = last ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        // The detect cycle is count 0 of the start bit, so the next one is 1.
        if (line_q && !sync2_q) begin
          state_d = S_START;
          div_d   = div_in;
          cnt_d   = DIV_W'(1);
          bit_d   = '0;
          stop_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (samp && vote) state_d = S_IDLE;
        else if (last)    state_d = S_DATA;
      end
      S_DATA: begin
        if (samp) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (last) begin
          if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else                             bit_d   = bit_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (samp) pbit_d  = vote;
        if (last) state_d = S_STOP;
      end
      S_STOP: begin
        if (samp) begin
          if (brk_now) begin
            push    = 1'b1;
            entry   = {1'b1, 1'b1, 1'b0, {DATA_BITS{1'b0}}};
            state_d = S_BRKWAIT;
          end else if (int'(stop_q) == STOP_BITS - 1) begin
            push    = 1'b1;
            entry   = {1'b0, fe_now, perr, shift_q};
            state_d = S_IDLE;
          end else begin
            ferr_d  = fe_now;
          end
        end
        if (last && state_d == S_STOP) stop_d = 1'b1;
      end
      S_BRKWAIT: if (sync2_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (!uart_rx_en) begin
      state_d = S_IDLE;
      push    = 1'b0;
    end
  end

  always_comb begin
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    pop       = (count_q != '0) && rx_ready;
    full      = (count_q == CW'(FIFO_DEPTH));
    do_push   = push && (!full || pop);
    overrun_d = push && full && !pop;
    if (do_push) begin
      mem_d[wptr_q] = entry;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE; sync1_q <= 1'b1; sync2_q <= 1'b1; line_q <= 1'b1;
      div_q   <= DIV_W'(4); cnt_q <= '0; s0_q <= 1'b1; s1_q <= 1'b1;
      bit_q   <= '0; stop_q <= 1'b0; pbit_q <= 1'b0; ferr_q <= 1'b0; shift_q <= '0;
      mem_q   <= '{default: '0};
      wptr_q  <= '0; rptr_q <= '0; count_q <= '0; overrun_q <= 1'b0;
    end else begin
      state_q <= state_d; sync1_q <= sync1_d; sync2_q <= sync2_d; line_q <= line_d;
      div_q   <= div_d;   cnt_q   <= cnt_d;   s0_q    <= s0_d;    s1_q   <= s1_d;
      bit_q   <= bit_d;   stop_q  <= stop_d;  pbit_q  <= pbit_d;  ferr_q <= ferr_d;
      shift_q <= shift_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;  rptr_q  <= rptr_d;  count_q <= count_d; overrun_q <= overrun_d;
    end
  end

  assign {rx_break, rx_frame_err, rx_parity_err, rx_data} = mem_q[rptr_q];
  assign rx_valid   = (count_q != '0);
  assign rx_count   = count_q;
  assign rx_overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three instances (8N1, 8E1, 8N2) driven by serial frames
// and compared against a frame-level reference model.
module tb_uart_rx_fifo;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [15:0] cfg_div = 16'd16;
  logic [2:0]  rxd = 3'b111;
  logic [2:0]  ready = 3'b000;
  logic [7:0]  dat [3];
  logic        pe [3], fe [3], brk [3], vld [3], ovr [3];
  logic [2:0]  cnt [3];

  int total = 0, bad = 0;
  int ovr_n [3];
  logic [10:0] got0[$], got1[$], got2[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(4)) u_n1 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd[0]), .uart_rx_en(en), .cfg_div(cfg_div),
    .rx_data(dat[0]), .rx_parity_err(pe[0]), .rx_frame_err(fe[0]), .rx_break(brk[0]),
    .rx_valid(vld[0]), .rx_ready(ready[0]), .rx_overrun(ovr[0]), .rx_count(cnt[0]));
  uart_rx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(4)) u_e1 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd[1]), .uart_rx_en(en), .cfg_div(cfg_div),
    .rx_data(dat[1]), .rx_parity_err(pe[1]), .rx_frame_err(fe[1]), .rx_break(brk[1]),
    .rx_valid(vld[1]), .rx_ready(ready[1]), .rx_overrun(ovr[1]), .rx_count(cnt[1]));
  uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .DIV_W(16), .FIFO_DEPTH(4)) u_n2 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd[2]), .uart_rx_en(en), .cfg_div(cfg_div),
    .rx_data(dat[2]), .rx_parity_err(pe[2]), .rx_frame_err(fe[2]), .rx_break(brk[2]),
    .rx_valid(vld[2]), .rx_ready(ready[2]), .rx_overrun(ovr[2]), .rx_count(cnt[2]));

  // Record every accepted head entry and every overrun pulse.
  always @(negedge clk) begin
    if (resetn) begin
      if (vld[0] && ready[0]) got0.push_back({brk[0], fe[0], pe[0], dat[0]});
      if (vld[1] && ready[1]) got1.push_back({brk[1], fe[1], pe[1], dat[1]});
      if (vld[2] && ready[2]) got2.push_back({brk[2], fe[2], pe[2], dat[2]});
      for (int k = 0; k < 3; k++) if (ovr[k]) ovr_n[k]++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_bits(input int n, input int bt);
    repeat (n * bt) tick();
  endtask

  // sel 0: 8N1, sel 1: 8E1, sel 2: 8N2. stops[0] is the first stop bit.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops, input int bt);
    rxd[sel] = 1'b0; wait_bits(1, bt);
    for (int i = 0; i < 8; i++) begin rxd[sel] = d[i]; wait_bits(1, bt); end
    if (sel == 1) begin rxd[sel] = pbit; wait_bits(1, bt); end
    rxd[sel] = stops[0]; wait_bits(1, bt);
    if (sel == 2) begin rxd[sel] = stops[1]; wait_bits(1, bt); end
    rxd[sel] = 1'b1; wait_bits(2, bt);
  endtask

  // Expected {break, frame_err, parity_err, data} for a frame as it was sent.
  function automatic logic [10:0] model(input int sel, input logic [7:0] d, input logic pbit,
                                        input logic [1:0] stops);
    int  ones;
    logic p_err, f_err;
    if (d == 8'h00 && (sel != 1 || pbit == 1'b0) && stops[0] == 1'b0) return 11'h600;
    ones  = $countones(d) + int'(pbit);
    p_err = (sel == 1) && (ones % 2 == 1);
    f_err = (stops[0] == 1'b0) || (sel == 2 && stops[1] == 1'b0);
    return {1'b0, f_err, p_err, d};
  endfunction

  function automatic int eff_div(input logic [15:0] v);
    return (v < 16'd4) ? 4 : int'(v);
  endfunction

  task automatic test_reset();
    resetn = 1'b0; en = 1'b1;
    repeat (3) tick();
    total++; if (vld[0] !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", vld[0]); end
    total++; if (cnt[0] !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cnt[0]); end
    total++; if (dat[0] !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", dat[0]); end
    total++; if ({brk[0], fe[0], pe[0]} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {brk[0], fe[0], pe[0]}); end
    total++; if (ovr[0] !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", ovr[0]); end
    resetn = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_basic_8n1();
    cfg_div = 16'd16; ready[0] = 1'b1; got0.delete();
    send_frame(0, 8'hA5, 1'b0, 2'b11, 16);
    total++; if (got0.size() != 1) begin bad++; $display("FAIL basic_beats got=%0d want=1", got0.size()); end
    else begin
      total++; if (got0[0] !== 11'h0A5) begin bad++; $display("FAIL basic_entry got=%h want=0a5", got0[0]); end
    end
    total++; if (cnt[0] !== 3'd0) begin bad++; $display("FAIL basic_count got=%0d want=0", cnt[0]); end
  endtask

  task automatic test_random_8n1();
    logic [10:0] exp_q[$];
    logic [7:0]  d;
    logic [1:0]  st;
    ready[0] = 1'b1; got0.delete();
    for (int i = 0; i < 16; i++) begin
      cfg_div = 16'($urandom_range(0, 24));
      d  = 8'($urandom);
      st = {1'b1, ($urandom_range(0, 3) != 0)};
      exp_q.push_back(model(0, d, 1'b0, st));
      send_frame(0, d, 1'b0, st, eff_div(cfg_div));
    end
    total++; if (got0.size() != exp_q.size()) begin
      bad++; $display("FAIL rand8n1_count got=%0d want=%0d", got0.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (got0[i] !== exp_q[i]) begin
        bad++; $display("FAIL rand8n1_entry%0d got=%h want=%h", i, got0[i], exp_q[i]); end
    end
  endtask

  task automatic test_parity_8e1();
    logic [10:0] exp_q[$];
    logic [7:0]  d;
    logic        p;
    cfg_div = 16'd16; ready[1] = 1'b1; got1.delete();
    send_frame(1, 8'h03, 1'b1, 2'b11, 16);
    send_frame(1, 8'h03, 1'b0, 2'b11, 16);
    total++; if (got1.size() != 2) begin bad++; $display("FAIL par_fixed_count got=%0d want=2", got1.size()); end
    else begin
      total++; if (got1[0] !== 11'h103) begin bad++; $display("FAIL par_bad got=%h want=103", got1[0]); end
      total++; if (got1[1] !== 11'h003) begin bad++; $display("FAIL par_good got=%h want=003", got1[1]); end
    end
    got1.delete();
    for (int i = 0; i < 10; i++) begin
      cfg_div = 16'($urandom_range(4, 20));
      d = 8'($urandom); p = 1'($urandom);
      exp_q.push_back(model(1, d, p, 2'b11));
      send_frame(1, d, p, 2'b11, eff_div(cfg_div));
    end
    total++; if (got1.size() != exp_q.size()) begin
      bad++; $display("FAIL par_rand_count got=%0d want=%0d", got1.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (got1[i] !== exp_q[i]) begin
        bad++; $display("FAIL par_rand_entry%0d got=%h want=%h", i, got1[i], exp_q[i]); end
    end
  endtask

  task automatic test_two_stop_8n2();
    logic [10:0] exp_q[$];
    logic [7:0]  d;
    logic [1:0]  st;
    cfg_div = 16'd16; ready[2] = 1'b1; got2.delete();
    send_frame(2, 8'h5A, 1'b0, 2'b01, 16);
    total++; if (got2.size() != 1) begin bad++; $display("FAIL stop2_count got=%0d want=1", got2.size()); end
    else begin
      total++; if (got2[0] !== 11'h25A) begin bad++; $display("FAIL stop2_entry got=%h want=25a", got2[0]); end
    end
    got2.delete();
    for (int i = 0; i < 10; i++) begin
      cfg_div = 16'($urandom_range(4, 20));
      d  = 8'($urandom_range(1, 255));
      st = 2'($urandom);
      exp_q.push_back(model(2, d, 1'b0, st));
      send_frame(2, d, 1'b0, st, eff_div(cfg_div));
    end
    total++; if (got2.size() != exp_q.size()) begin
      bad++; $display("FAIL stop2_rand_count got=%0d want=%0d", got2.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (got2[i] !== exp_q[i]) begin
        bad++; $display("FAIL stop2_rand_entry%0d got=%h want=%h", i, got2[i], exp_q[i]); end
    end
  endtask

  task automatic test_break();
    cfg_div = 16'd16; ready[0] = 1'b0; got0.delete();
    rxd[0] = 1'b0;
    wait_bits(11, 16);
    total++; if (cnt[0] !== 3'd1) begin bad++; $display("FAIL brk_count_low got=%0d want=1", cnt[0]); end
    wait_bits(1, 16);
    rxd[0] = 1'b1;
    wait_bits(2, 16);
    total++; if (cnt[0] !== 3'd1) begin bad++; $display("FAIL brk_count_high got=%0d want=1", cnt[0]); end
    total++; if ({vld[0], brk[0], fe[0], pe[0], dat[0]} !== {4'b1110, 8'h00}) begin
      bad++; $display("FAIL brk_head got=%b want=111000000000", {vld[0], brk[0], fe[0], pe[0], dat[0]}); end
    ready[0] = 1'b1; tick(); ready[0] = 1'b0; tick();
    total++; if (cnt[0] !== 3'd0 || got0.size() != 1) begin
      bad++; $display("FAIL brk_pop count=%0d beats=%0d want=0/1", cnt[0], got0.size()); end
  endtask

  task automatic test_overrun();
    logic [7:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    cfg_div = 16'd8; ready[0] = 1'b0; got0.delete(); ovr_n[0] = 0;
    for (int i = 0; i < 5; i++) send_frame(0, vals[i], 1'b0, 2'b11, 8);
    total++; if (cnt[0] !== 3'd4) begin bad++; $display("FAIL ovr_count got=%0d want=4", cnt[0]); end
    total++; if (ovr_n[0] != 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", ovr_n[0]); end
    ready[0] = 1'b1;
    repeat (8) tick();
    total++; if (got0.size() != 4) begin bad++; $display("FAIL ovr_drain got=%0d want=4", got0.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (got0[i] !== {3'b000, vals[i]}) begin
        bad++; $display("FAIL ovr_entry%0d got=%h want=%h", i, got0[i], {3'b000, vals[i]}); end
    end
  endtask

  task automatic test_glitch();
    cfg_div = 16'd16; ready[0] = 1'b0; got0.delete();
    rxd[0] = 1'b0; repeat (3) tick(); rxd[0] = 1'b1;
    wait_bits(3, 16);
    total++; if (cnt[0] !== 3'd0) begin bad++; $display("FAIL glitch_push got=%0d want=0", cnt[0]); end
    ready[0] = 1'b1;
    send_frame(0, 8'h96, 1'b0, 2'b11, 16);
    total++; if (got0.size() != 1 || got0[0] !== 11'h096) begin
      bad++; $display("FAIL glitch_recover beats=%0d want=1 (096)", got0.size()); end
  endtask

  task automatic test_enable_abort();
    cfg_div = 16'd16; ready[0] = 1'b0; got0.delete();
    send_frame(0, 8'h77, 1'b0, 2'b11, 16);
    total++; if (cnt[0] !== 3'd1) begin bad++; $display("FAIL en_prefill got=%0d want=1", cnt[0]); end
    rxd[0] = 1'b0; wait_bits(3, 16);
    en = 1'b0; wait_bits(1, 16);
    ready[0] = 1'b1; repeat (4) tick();
    total++; if (cnt[0] !== 3'd0) begin bad++; $display("FAIL en_pop_disabled got=%0d want=0", cnt[0]); end
    rxd[0] = 1'b1; wait_bits(2, 16);
    en = 1'b1; wait_bits(2, 16);
    total++; if (got0.size() != 1) begin bad++; $display("FAIL en_abort_push got=%0d want=1", got0.size()); end
    send_frame(0, 8'h3C, 1'b0, 2'b11, 16);
    total++; if (got0.size() != 2 || got0[got0.size()-1] !== 11'h03C) begin
      bad++; $display("FAIL en_next_frame beats=%0d want=2 (03c)", got0.size()); end
  endtask

  task automatic test_reset_midframe();
    cfg_div = 16'd16; ready[0] = 1'b0; got0.delete();
    send_frame(0, 8'h42, 1'b0, 2'b11, 16);
    rxd[0] = 1'b0; wait_bits(3, 16);
    resetn = 1'b0; tick();
    total++; if (cnt[0] !== 3'd0 || vld[0] !== 1'b0) begin
      bad++; $display("FAIL rst_mid_clear count=%0d valid=%b want=0/0", cnt[0], vld[0]); end
    repeat (3) tick();
    rxd[0] = 1'b1; repeat (4) tick();
    resetn = 1'b1; wait_bits(3, 16);
    total++; if (cnt[0] !== 3'd0) begin bad++; $display("FAIL rst_mid_push got=%0d want=0", cnt[0]); end
    ready[0] = 1'b1;
    send_frame(0, 8'h81, 1'b0, 2'b11, 16);
    total++; if (got0.size() != 1 || got0[0] !== 11'h081) begin
      bad++; $display("FAIL rst_mid_next beats=%0d want=1 (081)", got0.size()); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) ovr_n[k] = 0;
    test_reset();
    test_basic_8n1();
    test_random_8n1();
    test_parity_8e1();
    test_two_stop_8n2();
    test_break();
    test_overrun();
    test_glitch();
    test_enable_abort();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
